// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: the mainmem address/data port and the decode-side
// valid/ready instruction handshake. The fetch unit uses the master view,
// memory and decode sit on the slave view.
interface fetch_unit_if;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output mem_address,
    output mem_read_write,
    output mem_data_in,
    input  mem_data_out,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  mem_address,
    input  mem_read_write,
    input  mem_data_in,
    output mem_data_out,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, reads mainmem combinationally and
// captures {pc, word} into a show-ahead prefetch FIFO drained by decode.
// Redirects flush the FIFO and reload the PC; an out-of-range or misaligned
// PC latches a sticky fault and stops fetching (FIFO stays drainable).
// Optional feature macro: FETCH_PERF_EN adds saturating perf_fetched /
// perf_stalled counters.
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = 32'h01000000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h00100000,
  parameter int          DEPTH           = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  fetch_unit_if.master bus,
  output logic         fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stalled
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FULL, FAULT} state_t;

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [32:0]   RANGE_LO = {1'b0, STARTING_ADDR};
  localparam logic [32:0]   RANGE_HI = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES};

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic head_valid;
  logic redir;
  logic pop;
  logic fetch_active;
  logic pc_ok;
  logic has_room;
  logic push;
  logic violation;

  // Redirect is ignored once faulted; otherwise it overrides push and pop.
  assign head_valid   = (count != '0);
  assign redir        = redirect_valid && (state != FAULT);
  assign pop          = head_valid && bus.inst_ready;
  assign fetch_active = ((state == RUN) || (state == FULL)) && fetch_en && !redir;
  // 33-bit compare so a PC that wrapped past 'hFFFFFFFC still lands out of range.
  assign pc_ok        = ({1'b0, pc} >= RANGE_LO) && ({1'b0, pc} < RANGE_HI) &&
                        (pc[1:0] == 2'b00);
  assign has_room     = (count < DEPTH_C) || pop;
  assign push         = fetch_active && pc_ok && has_room;
  assign violation    = fetch_active && !pc_ok;
  assign count_nxt    = redir ? '0 : (count + CW'(push) - CW'(pop));

  assign bus.mem_address    = pc;
  assign bus.mem_read_write = 1'b0;
  assign bus.mem_data_in    = 32'h0;
  assign bus.inst_valid     = head_valid;
  assign bus.inst           = head_valid ? fifo_word[rd_ptr] : 32'h0;
  assign bus.inst_pc        = head_valid ? fifo_pc[rd_ptr]   : 32'h0;

  // Control: FSM, PC, FIFO pointers/occupancy and the sticky fault flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= STARTING_ADDR;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fault  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (redir) begin
        pc     <= redirect_target;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end

      case (state)
        IDLE: begin
          if (fetch_en) state <= RUN;
        end
        RUN: begin
          if (violation) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (!fetch_en) begin
            state <= IDLE;
          end else if (!redir && !pop && (count_nxt == DEPTH_C)) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (violation) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (redir || pop) begin
            state <= RUN;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  // FIFO storage: data only, no reset needed since occupancy gates the head.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_word[wr_ptr] <= bus.mem_data_out;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : (v + 32'd1);
  endfunction

  // Saturating counters: words pushed, and cycles spent stalled in FULL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'h0;
      perf_stalled <= 32'h0;
    end else begin
      if (push)          perf_fetched <= sat_inc(perf_fetched);
      if (state == FULL) perf_stalled <= sat_inc(perf_stalled);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a mainmem model feeds mem_data_out, directed
// stimulus pushes the expected {pc, word} of every instruction decode will
// accept into a queue, and a negedge monitor pops and compares each accepted
// instruction. Direct checks cover reset, latency, FULL stall, redirect,
// fault and asynchronous reset.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
`endif

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  fetch_unit_if bus ();

  fetch_unit #(
    .STARTING_ADDR   (32'h01000000),
    .MEM_DEPTH_BYTES (32'h00100000),
    .DEPTH           (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus),
    .fault           (fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stalled    (perf_stalled)
`endif
  );

  always #5 clock = ~clock;

  // Main memory contents: a known opcode at the base, an address hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h01000000) return 32'h00000093;
    return {a[15:0] ^ 16'h1234, ~a[31:16]};
  endfunction

  assign bus.mem_data_out = mem_word(bus.mem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] first_pc, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({first_pc + 32'(4 * i), mem_word(first_pc + 32'(4 * i))});
  endtask

  // Monitor: every accepted instruction must match the queue head.
  always @(negedge clock) begin
    if (reset_n && bus.inst_valid && bus.inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop actual_pc=%h actual_inst=%h required=none",
                 bus.inst_pc, bus.inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.inst_pc, bus.inst} !== e) begin
          failures++;
          $display("FAIL popped_inst actual_pc=%h actual_inst=%h required_pc=%h required_inst=%h",
                   bus.inst_pc, bus.inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    bus.inst_ready = 1'b0;
    #1 reset_n = 1'b0;
    fetch_en = 1'b1;
    #1;
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_mem_address", bus.mem_address, 32'h01000000);
    check("rst_read_write", 32'(bus.mem_read_write), 32'h0);
    check("rst_data_in", bus.mem_data_in, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
`endif
    tick();
    reset_n = 1'b1;

    // IDLE->RUN at E1, first push at E2.
    tick();
    check("lat_valid_e1", 32'(bus.inst_valid), 32'h0);
    tick();
    check("lat_valid_e2", 32'(bus.inst_valid), 32'h1);
    check("first_inst", bus.inst, 32'h00000093);
    check("first_inst_pc", bus.inst_pc, 32'h01000000);
    check("addr_after_first", bus.mem_address, 32'h01000004);

    // Decode stalled: four pushes, then FULL holds the PC.
    repeat (8) tick();
    check("full_mem_address", bus.mem_address, 32'h01000010);
    check("full_head_pc", bus.inst_pc, 32'h01000000);
    check("full_valid", 32'(bus.inst_valid), 32'h1);

    // Release decode: in-order drain with no gaps.
    expect_seq(32'h01000000, 8);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", 32'(bus.inst_valid), 32'h1);
    end
    bus.inst_ready = 1'b0;
    tick();

    // Pop one with fetching disabled to leave 3 entries, then go IDLE.
    fetch_en = 1'b0;
    bus.inst_ready = 1'b1;
    expect_seq(32'h01000020, 1);
    tick();
    bus.inst_ready = 1'b0;
    tick();
    check("three_left_valid", 32'(bus.inst_valid), 32'h1);

    // Redirect flushes the FIFO at its edge; target presented one edge later.
    redirect_valid = 1'b1;
    redirect_target = 32'h01000040;
    fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(bus.inst_valid), 32'h0);
    check("redir_mem_address", bus.mem_address, 32'h01000040);
    tick();
    check("redir_valid", 32'(bus.inst_valid), 32'h1);
    check("redir_inst_pc", bus.inst_pc, 32'h01000040);
    expect_seq(32'h01000040, 4);
    bus.inst_ready = 1'b1;
    repeat (4) tick();
    bus.inst_ready = 1'b0;

    // Misaligned redirect target faults on the following RUN cycle.
    redirect_valid = 1'b1;
    redirect_target = 32'h01000002;
    tick();
    redirect_valid = 1'b0;
    check("misalign_fault_pre", 32'(fault), 32'h0);
    tick();
    check("misalign_fault", 32'(fault), 32'h1);
    check("misalign_addr", bus.mem_address, 32'h01000002);
    check("misalign_no_push", 32'(bus.inst_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_target = 32'h01000100;
    repeat (3) tick();
    redirect_valid = 1'b0;
    check("fault_addr_frozen", bus.mem_address, 32'h01000002);
    check("fault_sticky", 32'(fault), 32'h1);
    check("fault_no_push", 32'(bus.inst_valid), 32'h0);

    // Reset clears the fault; then fetch up to the top of the region.
    reset_n = 1'b0;
    #1;
    check("rst2_fault", 32'(fault), 32'h0);
    tick();
    reset_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h010FFFF0;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("top_first_pc", bus.inst_pc, 32'h010FFFF0);
    repeat (3) tick();
    check("top_fault_pre", 32'(fault), 32'h0);
    check("top_end_addr", bus.mem_address, 32'h01100000);
    tick();
    check("top_fault", 32'(fault), 32'h1);
    check("top_head_pc", bus.inst_pc, 32'h010FFFF0);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'h4);
`endif
    // FIFO contents stay drainable after the fault.
    expect_seq(32'h010FFFF0, 2);
    bus.inst_ready = 1'b1;
    repeat (2) tick();
    bus.inst_ready = 1'b0;
    check("drain_head_pc", bus.inst_pc, 32'h010FFFF8);

    // Asynchronous reset between edges with the FIFO non-empty.
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.inst_valid), 32'h0);
    check("async_rst_addr", bus.mem_address, 32'h01000000);
    check("async_rst_inst_pc", bus.inst_pc, 32'h0);
    check("async_rst_fault", 32'(fault), 32'h0);
`ifdef FETCH_PERF_EN
    check("async_rst_perf", perf_fetched, 32'h0);
`endif
    tick();
    fetch_en = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_rst_valid", 32'(bus.inst_valid), 32'h0);
    check("post_rst_addr", bus.mem_address, 32'h01000000);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch initiator for `mainmem`: owns the program counter and drives `mainmem`'s address and read/write inputs. It captures each returned word, tagged with its PC, into a small prefetch FIFO. The decode stage drains the FIFO through a valid/ready handshake. A redirect input lets the later pipeline steer the PC for branches and jumps. The unit sits between main memory and decode in the single-cycle-memory processor.

## Interface
- `STARTING_ADDR`, default `'h01000000`: reset PC and memory base address.
- `MEM_DEPTH_BYTES`, default `'h0100000`: size of the fetchable region in bytes.
- `DEPTH`, default 4: number of prefetch FIFO entries; must be a power of 2, at least 2.

- `clock`  in  1  system clock; all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  fetching is permitted while high.
- `mem_address`  out  32  to `mainmem` `address`; equals the `pc` register.
- `mem_read_write`  out  1  to `mainmem` `read_write`; constant 0 (READ).
- `mem_data_in`  out  32  to `mainmem` `data_in`; constant 0.
- `mem_data_out`  in  32  from `mainmem` `data_out`; combinational read of `mem_address`.
- `redirect_valid`  in  1  load a new PC.
- `redirect_target`  in  32  new PC value.
- `inst_valid`  out  1  FIFO head holds an instruction.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  PC of the head instruction.
- `fault`  out  1  sticky flag: out-of-range or misaligned PC.

## Operation
- FSM states:
  - `IDLE` → `RUN` when `fetch_en` is high.
  - `RUN` → `IDLE` when `fetch_en` is low.
  - `RUN` → `FULL` when FIFO occupancy reaches `DEPTH` and there is no pop that cycle.
  - `FULL` → `RUN` on a pop.
  - any state → `FAULT` on a range or alignment violation.
  - `FAULT` is left only by reset.
- Push: in `RUN`, when there is no redirect and the FIFO has room (occupancy < `DEPTH`, or a pop happens in the same cycle), the unit captures `{pc, mem_data_out}` into the FIFO and sets `pc <= pc + 4`.
- Range check: a PC is valid only if `STARTING_ADDR <= pc < STARTING_ADDR + MEM_DEPTH_BYTES` and `pc[1:0] == 0`.
  - An invalid PC in `RUN` does not push.
  - It sets `fault` and moves the FSM to `FAULT`.
  - FIFO contents remain drainable.
- Pop: `inst_valid && inst_ready`. The FIFO is show-ahead; `inst` and `inst_pc` are the head entry, driven to 0 when the FIFO is empty.
- Redirect: has priority over push and pop in the same cycle.
  - Flushes the FIFO (occupancy = 0).
  - Sets `pc <= redirect_target`.
  - Takes effect in any state except `FAULT`, and does not change state, except that `FULL` → `RUN`.
  - A misaligned or out-of-range target faults on the next `RUN` cycle.
- PC arithmetic is 32-bit modulo 2^32; wrap past `'hFFFFFFFC` is caught by the range check.
- Occupancy counter is log2(`DEPTH`)+1 bits; read and write pointers are log2(`DEPTH`) bits with natural wrap.

## Timing
- Reset values:
  - `pc = STARTING_ADDR`, FSM in `IDLE`, occupancy 0.
  - `inst_valid = 0`, `inst = 0`, `inst_pc = 0`, `fault = 0`.
  - `mem_read_write = 0`, `mem_data_in = 0`, `mem_address = STARTING_ADDR`.
- Fetch latency: `mem_address` changes right after a posedge. The word is captured at the next posedge, and `inst_valid` rises right after that posedge, i.e. 1 cycle from address to valid.
- Sustained throughput: 1 instruction per cycle while decode holds `inst_ready` high.
- Redirect asserted at edge N: the instruction at the new target is presented with `inst_valid` after edge N+1.
- Full FIFO with a pop at the same edge: push and pop both occur and occupancy is unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously; the FIFO is empty at deassertion.

## Configuration
- `FETCH_PERF_EN` defined: adds two 32-bit outputs, reset to 0 and saturating at `'hFFFFFFFF`.
  - `perf_fetched`: increments on every push.
  - `perf_stalled`: increments every cycle spent in `FULL`.
- `FETCH_PERF_EN` not defined: neither port nor the counters exist.

## Test plan
- Reset, `fetch_en = 1`, `inst_ready = 1`, memory holds `'h00000093` at `'h01000000` → `inst_valid` rises 1 cycle after the first edge with `inst = 'h00000093`, `inst_pc = 'h01000000`. PCs then step by 4 every cycle.
- `inst_ready = 0` for 10 cycles → exactly 4 pushes, FSM reaches `FULL` and `mem_address` holds `'h01000010`. Releasing `inst_ready` drains the FIFO in order with no gaps.
- `redirect_valid` with target `'h01000040` while the FIFO holds 3 entries → occupancy becomes 0 that edge and the next presented `inst_pc = 'h01000040`.
- Redirect target `'h01000002` → `fault = 1` one cycle later, no further pushes, and `mem_address` stays frozen.
- Sequential fetch reaching `'h01100000` → `fault` asserts with `'h010FFFFC` as the last valid `inst_pc`.
- Reset pulse asserted mid-stream between edges → `inst_valid = 0` and `mem_address = 'h01000000` immediately. With `FETCH_PERF_EN` defined, `perf_fetched` equals the count of pop-able words and clears on reset.
